// File: rtl/lut_loader_pkg.sv
// Shared types and helpers for the runtime-loadable neuron LUT.
package lut_loader_pkg;

    typedef enum logic [1:0] {EMPTY, LOAD, READY, ERR} state_t;

    localparam int IN_BITS_DEF  = 8;
    localparam int BW_DEF       = 2;
    localparam int OUT_BITS_DEF = 2;
    localparam int DEPTH        = 1 << IN_BITS_DEF;

    // Digit reversal by BW-bit field: digit i of the entry index lands in
    // the i-th field counted from the top of the lookup code.
    function automatic logic [31:0] perm(input logic [31:0] code, input int in_bits, input int bw);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < in_bits) begin
                r[in_bits - (b / bw + 1) * bw + (b % bw)] = code[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lut_ram.sv
// Distributed LUT storage: synchronous write, registered read with enable.
module lut_ram #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IN_BITS-1:0]  waddr,
    input  logic [OUT_BITS-1:0] wdata,
    input  logic                re,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int NUM_ENTRIES = 1 << IN_BITS;

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array contents are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lut_table_loader.sv
// LogicNets neuron whose truth table is loaded over a valid/ready stream.
module lut_table_loader
    import lut_loader_pkg::*;
#(
    parameter int IN_BITS  = IN_BITS_DEF,
    parameter int BW       = BW_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    output logic                load_done,
    output logic                load_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] M1
);

    localparam int NUM_ENTRIES = 1 << IN_BITS;
    localparam logic [IN_BITS:0] K_FINAL = (IN_BITS+1)'(NUM_ENTRIES - 1);

    state_t             state;
    logic [IN_BITS:0]   k;
    logic               wr_en;
    logic               rd_en;
    logic [IN_BITS-1:0] wr_addr;

    // A restart in the same cycle as a transfer discards the entry.
    assign wr_en   = (state == LOAD) && cfg_valid && !cfg_start;
    assign rd_en   = (state == READY) && in_valid;
    assign wr_addr = IN_BITS'(perm(32'(k[IN_BITS-1:0]), IN_BITS, BW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            k         <= '0;
            cfg_ready <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            if (cfg_start) begin
                state     <= LOAD;
                k         <= '0;
                cfg_ready <= 1'b1;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else if (wr_en) begin
                k <= k + 1'b1;
                if (k == K_FINAL) begin
                    state     <= cfg_last ? READY : ERR;
                    cfg_ready <= 1'b0;
                    load_done <= cfg_last;
                    load_err  <= !cfg_last;
                end else if (cfg_last) begin
                    state     <= ERR;
                    cfg_ready <= 1'b0;
                    load_err  <= 1'b1;
                end
            end
        end
    end

    lut_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (cfg_data),
        .re    (rd_en),
        .raddr (M0),
        .rdata (M1)
    );

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader at default parameters.
module tb_lut_table_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_data = '0;
    logic       cfg_last = 1'b0;
    logic       load_done;
    logic       load_err;
    logic       in_valid = 1'b0;
    logic [7:0] M0 = '0;
    logic       out_valid;
    logic [1:0] M1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lut_table_loader #(.IN_BITS(8), .BW(2), .OUT_BITS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .load_done (load_done),
        .load_err  (load_err),
        .in_valid  (in_valid),
        .M0        (M0),
        .out_valid (out_valid),
        .M1        (M1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    // pat 0: entry k holds k mod 4; pat 1: entry k holds k[7:6].
    function automatic logic [1:0] entry(input int pat, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        return (pat == 0) ? kk[1:0] : kk[7:6];
    endfunction

    task automatic load(input int pat, input int last_at, input int stop_at, input bit gaps);
        for (int k = 0; k < 256; k++) begin
            if (k == stop_at) return;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                cfg_valid = 1'b0;
                step();
            end
            cfg_valid = 1'b1;
            cfg_data  = entry(pat, k);
            cfg_last  = (k == last_at);
            step();
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            if (k == last_at) return;
        end
    endtask

    task automatic lookup(input string tag, input logic [7:0] code, input logic [1:0] exp);
        in_valid = 1'b1;
        M0 = code;
        step();
        in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_m1"}, 32'(M1), 32'(exp));
        step();
        chk({tag, "_hold"}, 32'({out_valid, M1}), 32'({1'b0, exp}));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_ovld", 32'(out_valid), 32'd0);
        chk("rst_m1", 32'(M1), 32'd0);
        rst_n = 1'b1;
        step();

        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("empty_lookup", 32'(out_valid), 32'd0);

        // Restart together with a valid entry: the entry must be dropped
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 2'b11;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("start_ready", 32'(cfg_ready), 32'd1);
        chk("start_done", 32'(load_done), 32'd0);

        // Pattern A
        load(0, 255, -1, 1'b0);
        chk("a_done", 32'(load_done), 32'd1);
        chk("a_err", 32'(load_err), 32'd0);
        chk("a_ready", 32'(cfg_ready), 32'd0);
        lookup("a_lk0", 8'b10110001, 2'b10);
        lookup("a_lk1", 8'b01000000, 2'b01);

        // Pattern B
        start_load();
        chk("b_done_clr", 32'(load_done), 32'd0);
        load(1, 255, -1, 1'b0);
        chk("b_done", 32'(load_done), 32'd1);
        lookup("b_lk0", 8'b10110001, 2'b01);
        lookup("b_lk1", 8'b00000011, 2'b11);

        // Back-to-back lookups; restart lands with the final request
        for (int i = 0; i < 256; i++) begin
            in_valid  = 1'b1;
            M0        = 8'(i);
            cfg_start = (i == 255);
            step();
            chk("b2b_vld", 32'(out_valid), 32'd1);
            chk("b2b_m1", 32'(M1), 32'(i % 4));
        end
        cfg_start = 1'b0;
        step();
        in_valid = 1'b0;
        chk("b2b_after_start", 32'(out_valid), 32'd0);
        chk("b2b_load_ready", 32'(cfg_ready), 32'd1);

        // Early cfg_last
        start_load();
        load(0, 100, -1, 1'b0);
        chk("early_err", 32'(load_err), 32'd1);
        chk("early_ready", 32'(cfg_ready), 32'd0);
        chk("early_done", 32'(load_done), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("err_lookup", 32'(out_valid), 32'd0);
        step();
        chk("err_persist", 32'(load_err), 32'd1);

        // Recovery load with random gaps
        start_load();
        chk("rec_err_clr", 32'(load_err), 32'd0);
        load(0, 255, -1, 1'b1);
        chk("rec_done", 32'(load_done), 32'd1);
        lookup("rec_lk0", 8'b11000000, 2'b11);
        lookup("rec_lk1", 8'b00111111, 2'b00);
        lookup("rec_lk2", 8'b10110001, 2'b10);

        // Missing cfg_last on the final entry
        start_load();
        load(1, -1, -1, 1'b0);
        chk("nolast_err", 32'(load_err), 32'd1);
        chk("nolast_done", 32'(load_done), 32'd0);
        chk("nolast_ready", 32'(cfg_ready), 32'd0);

        // Asynchronous reset in the middle of a load
        start_load();
        load(1, 255, 37, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
        chk("mid_rst_outs", 32'({load_done, load_err, out_valid, M1}), 32'd0);
        cfg_valid = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_lookup", 32'(out_valid), 32'd0);
        start_load();
        load(1, 255, -1, 1'b0);
        chk("reload_done", 32'(load_done), 32'd1);
        lookup("reload_lk", 8'b01010110, 2'b10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
